// File: rtl/ship_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : ship_button_conditioner_if
// Brief    : Raw button levels in, debounced levels and move strobes out.
// Revision : 1.0
// ============================================================================
interface ship_button_conditioner_if;
    logic i_left_raw;
    logic i_right_raw;
    logic o_left_held;
    logic o_right_held;
    logic o_left_debounced;
    logic o_right_debounced;

    modport master (
        output i_left_raw,
        output i_right_raw,
        input  o_left_held,
        input  o_right_held,
        input  o_left_debounced,
        input  o_right_debounced
    );

    modport slave (
        input  i_left_raw,
        input  i_right_raw,
        output o_left_held,
        output o_right_held,
        output o_left_debounced,
        output o_right_debounced
    );
endinterface
`default_nettype wire

// File: rtl/ship_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ship_button_conditioner
// Brief    : Synchronise, debounce and strobe the left/right ship buttons.
//            Auto-repeat is built only when SHIP_AUTOREPEAT_EN is defined.
// Revision : 1.0
// ============================================================================
module ship_button_conditioner #(
    parameter int DEBOUNCE_CYCLES      = 360000,
    parameter int REPEAT_DELAY_CYCLES  = 9000000,
    parameter int REPEAT_PERIOD_CYCLES = 3600000,
    parameter int CNT_W                = 24
) (
    input  wire logic                 i_clk_36MHz,
    input  wire logic                 i_reset,
    ship_button_conditioner_if.slave  io_btn
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_DELAY        = 2'd1,
        ST_REPEAT       = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_PERIOD_CYCLES < 2) || (REPEAT_DELAY_CYCLES < 1) ||
        (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(REPEAT_DELAY_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(REPEAT_PERIOD_CYCLES) > (64'd1 << CNT_W))) begin : g_param_check
        $error("ship_button_conditioner: illegal parameter set");
    end

    logic [1:0] w_raw;
    logic [1:0] w_held;
    logic [1:0] w_held_nxt;
    logic [1:0] w_fire;
    logic       w_conflict;
    logic [1:0] r_strobe;

    assign w_raw = {io_btn.i_right_raw, io_btn.i_left_raw};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic             r_meta;
        logic             r_sync;
        logic             r_held;
        logic [CNT_W-1:0] r_deb_cnt;
        logic             w_mismatch;
        logic             w_deb_done;
        state_t           r_state;

        always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
            if (!i_reset) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
            end else begin
                r_meta <= w_raw[g];
                r_sync <= r_meta;
            end
        end

        assign w_mismatch = r_sync ^ r_held;
        assign w_deb_done = w_mismatch && (r_deb_cnt == c_deb_last);

        // Any sample agreeing with the stable level restarts the count.
        always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
            if (!i_reset) begin
                r_deb_cnt <= '0;
                r_held    <= 1'b0;
            end else begin
                if (!w_mismatch || w_deb_done) begin
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + c_one;
                end
                if (w_deb_done) begin
                    r_held <= ~r_held;
                end
            end
        end

        assign w_held[g]     = r_held;
        assign w_held_nxt[g] = r_held ^ w_deb_done;

`ifdef SHIP_AUTOREPEAT_EN
        localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
        localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD_CYCLES - 1);

        logic [CNT_W-1:0] r_rep_cnt;
        logic             w_delay_done;
        logic             w_period_done;

        assign w_delay_done  = (r_state == ST_DELAY)  && (r_rep_cnt == c_delay_last);
        assign w_period_done = (r_state == ST_REPEAT) && (r_rep_cnt == c_period_last);
        assign w_fire[g]     = r_held && ((r_state == ST_IDLE) || w_delay_done || w_period_done);

        always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
            if (!i_reset) begin
                r_state   <= ST_IDLE;
                r_rep_cnt <= '0;
            end else if (!r_held) begin
                r_state   <= ST_IDLE;
                r_rep_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_DELAY;
                        r_rep_cnt <= '0;
                    end
                    ST_DELAY: begin
                        if (w_delay_done) begin
                            r_state   <= ST_REPEAT;
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_one;
                        end
                    end
                    ST_REPEAT: begin
                        if (w_period_done) begin
                            r_rep_cnt <= '0;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_one;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_rep_cnt <= '0;
                    end
                endcase
            end
        end
`else
        assign w_fire[g] = r_held && (r_state == ST_IDLE);

        always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
            if (!i_reset) begin
                r_state <= ST_IDLE;
            end else if (!r_held) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                r_state <= ST_WAIT_RELEASE;
            end
        end
`endif
    end

    // Mask on the held levels the strobe cycle will show; a simultaneous
    // fire on both channels is dropped so the strobes stay exclusive.
    assign w_conflict = (&w_held_nxt) | (&w_fire);

    always_ff @(posedge i_clk_36MHz or negedge i_reset) begin
        if (!i_reset) begin
            r_strobe <= 2'b00;
        end else begin
            r_strobe <= w_fire & {2{~w_conflict}};
        end
    end

    assign io_btn.o_left_held       = w_held[0];
    assign io_btn.o_right_held      = w_held[1];
    assign io_btn.o_left_debounced  = r_strobe[0];
    assign io_btn.o_right_debounced = r_strobe[1];

endmodule
`default_nettype wire

// File: tb/tb_ship_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_button_conditioner
// Brief    : Scenario tasks plus random presses checked against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_ship_button_conditioner;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int CW  = 8;
`ifdef SHIP_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ship_button_conditioner_if btn ();

    ship_button_conditioner #(
        .DEBOUNCE_CYCLES      (DEB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP),
        .CNT_W                (CW)
    ) dut (
        .i_clk_36MHz (clk),
        .i_reset     (rst_n),
        .io_btn      (btn)
    );

    always #5 clk = ~clk;

    // Reference: raw history gives the synchronised sample, a run length of
    // disagreeing samples flips the level, press age sets the strobe times.
    bit m_h1 [2];
    bit m_h2 [2];
    bit m_held [2];
    bit m_stb [2];
    int m_run [2];
    int m_age [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_h1[c] = 0; m_h2[c] = 0; m_held[c] = 0; m_stb[c] = 0;
            m_run[c] = 0; m_age[c] = -1;
        end
    endtask

    task automatic model_step(input bit l, input bit r);
        bit raw [2];
        bit fire [2];
        bit nheld [2];
        raw[0] = l;
        raw[1] = r;
        for (int c = 0; c < 2; c++) begin
            fire[c] = 0;
            if (m_held[c]) begin
                m_age[c]++;
                if (m_age[c] == 0) fire[c] = 1;
                else if (AR && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0) fire[c] = 1;
            end else begin
                m_age[c] = -1;
            end
            nheld[c] = m_held[c];
            if (m_h2[c] != m_held[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    nheld[c] = ~m_held[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_h2[c] = m_h1[c];
            m_h1[c] = raw[c];
        end
        for (int c = 0; c < 2; c++) m_held[c] = nheld[c];
        for (int c = 0; c < 2; c++)
            m_stb[c] = fire[c] && !(fire[0] && fire[1]) && !(nheld[0] && nheld[1]);
    endtask

    function automatic logic [3:0] obs();
        return {btn.o_left_held, btn.o_right_held, btn.o_left_debounced, btn.o_right_debounced};
    endfunction

    function automatic logic [3:0] expv();
        return {m_held[0], m_held[1], m_stb[0], m_stb[1]};
    endfunction

    task automatic step_cycle(input bit l, input bit r);
        @(negedge clk);
        btn.i_left_raw  = l;
        btn.i_right_raw = r;
        @(posedge clk);
        #1;
        model_step(l, r);
    endtask

    task automatic test_reset();
        int held_rise;
        int first_stb;
        int nstb;
        rst_n = 1'b0;
        btn.i_left_raw  = 1'b1;
        btn.i_right_raw = 1'b0;
        model_reset();
        repeat (20) begin
            @(posedge clk); #1;
            checks++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL reset_state: got=%b exp=0000 t=%0t", obs(), $time);
            end
        end
        rst_n = 1'b1;
        held_rise = -1; first_stb = -1; nstb = 0;
        for (int n = 1; n <= 9; n++) begin
            step_cycle(1, 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_release_model: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            if (btn.o_left_held && held_rise < 0) held_rise = n;
            if (btn.o_left_debounced) begin
                nstb++;
                if (first_stb < 0) first_stb = n;
            end
        end
        checks++;
        if (held_rise != 6) begin
            errors++;
            $display("FAIL reset_release_held: got cycle %0d exp 6", held_rise);
        end
        checks++;
        if (first_stb != 7 || nstb != 1) begin
            errors++;
            $display("FAIL reset_release_strobe: got first=%0d count=%0d exp first=7 count=1", first_stb, nstb);
        end
    endtask

    task automatic test_bounce();
        for (int n = 0; n < 12; n++) begin
            step_cycle(0, 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL bounce_settle: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
        end
        for (int n = 0; n < 30; n++) begin
            step_cycle(((n / 2) % 2) == 0, 0);
            checks++;
            if (obs() !== expv() || obs() !== 4'b0000) begin
                errors++;
                $display("FAIL bounce_filter: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
        end
    endtask

    task automatic test_autorepeat();
        int got_q[$];
        int exp_q[$];
        int fall;
        int late;
        exp_q.push_back(7);
        if (AR) for (int t = 7 + RD; t <= 40; t += RP) exp_q.push_back(t);
        for (int n = 1; n <= 40; n++) begin
            step_cycle(0, 1);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL repeat_model: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            if (btn.o_right_debounced) got_q.push_back(n);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL repeat_count: got %0d strobes exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL repeat_time[%0d]: got cycle %0d exp %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
        fall = -1; late = 0;
        for (int n = 1; n <= 15; n++) begin
            step_cycle(0, 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL release_model: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            if (!btn.o_right_held && fall < 0) fall = n;
            if (btn.o_right_debounced) late++;
        end
        checks++;
        if (fall != 6 || late != 0) begin
            errors++;
            $display("FAIL release_timing: got fall=%0d strobes=%0d exp fall=6 strobes=0", fall, late);
        end
    endtask

    task automatic test_conflict();
        bit l;
        bit r;
        for (int n = 0; n < 82; n++) begin
            l = (n < 70);
            r = (n >= 20 && n < 40);
            step_cycle(l, r);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL conflict_model: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            checks++;
            if ((btn.o_left_held && btn.o_right_held && (btn.o_left_debounced || btn.o_right_debounced)) ||
                (btn.o_left_debounced && btn.o_right_debounced)) begin
                errors++;
                $display("FAIL conflict_suppress: got=%b cyc=%0d", obs(), n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_stb;
        int nstb;
        for (int n = 0; n < 25; n++) begin
            step_cycle(1, 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midrst_pre: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got=%b exp=0000", obs());
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        first_stb = -1; nstb = 0;
        for (int n = 1; n <= 9; n++) begin
            step_cycle(1, 0);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL midrst_post: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            if (btn.o_left_debounced) begin
                nstb++;
                if (first_stb < 0) first_stb = n;
            end
        end
        checks++;
        if (first_stb != 7 || nstb != 1) begin
            errors++;
            $display("FAIL midrst_strobe: got first=%0d count=%0d exp first=7 count=1", first_stb, nstb);
        end
    endtask

    task automatic test_random();
        bit lvl [2];
        int rem [2];
        lvl[0] = 1; lvl[1] = 0; rem[0] = 0; rem[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = bit'($urandom_range(0, 1));
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
                end
                rem[c]--;
            end
            step_cycle(lvl[0], lvl[1]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random_model: got=%b exp=%b cyc=%0d", obs(), expv(), n);
            end
            checks++;
            if (btn.o_left_debounced && btn.o_right_debounced) begin
                errors++;
                $display("FAIL random_exclusive: got=%b cyc=%0d", obs(), n);
            end
        end
    endtask

    initial begin
        btn.i_left_raw  = 1'b0;
        btn.i_right_raw = 1'b0;
        test_reset();
        test_bounce();
        test_autorepeat();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ship_button_conditioner.md
Name: ship_button_conditioner

Overview:
- Converts raw, bouncy left/right push-button levels into the move strobes consumed by the ship position logic (i_left_debounced / i_right_debounced).
- Per channel: synchronise, debounce, then generate a one-cycle move strobe on press, with auto-repeat while held.
- Sits between the board button pins and the ship block, in the i_clk_36MHz domain.

Parameters:
- DEBOUNCE_CYCLES, 360000: cycles an input must hold a new value before the stable level changes (10 ms at 36 MHz); min 2.
- REPEAT_DELAY_CYCLES, 9000000: cycles from the first strobe to the first repeat strobe (250 ms).
- REPEAT_PERIOD_CYCLES, 3600000: cycles between subsequent repeat strobes (100 ms); min 2.
- CNT_W, 24: counter width; must hold max(parameter) - 1.

Ports:
- i_clk_36MHz  input  1  system clock
- i_reset  input  1  asynchronous, active-low reset (0 = reset)
- i_left_raw  input  1  raw left button, active high, asynchronous to clock
- i_right_raw  input  1  raw right button, active high, asynchronous to clock
- o_left_held  output  1  debounced stable level, left
- o_right_held  output  1  debounced stable level, right
- o_left_debounced  output  1  one-cycle left move strobe
- o_right_debounced  output  1  one-cycle right move strobe

Behaviour:
- Reset, i_reset=0 asynchronous: all sync flops, counters, FSMs and outputs go to 0, FSM to IDLE. No strobe is issued at reset release, even with a button held. A held button must re-debounce from scratch.
- Reset mid-operation aborts any debounce or repeat in progress.
- Synchroniser: 2-flop per raw input. s = second-stage output.
- Debounce filter, per channel:
  - If s == held, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s != held, held toggles on the next edge and the counter clears.
  - Any glitch back to the held value restarts the count.
  - Latency from a clean raw edge to held change: 2 + DEBOUNCE_CYCLES cycles.
- Strobe FSM, per channel, with states IDLE, DELAY, REPEAT:
  - IDLE, held rises: strobe high for exactly the next cycle, go to DELAY with the repeat counter at 0.
  - DELAY: count. At REPEAT_DELAY_CYCLES-1, strobe for one cycle and go to REPEAT with the counter cleared.
  - REPEAT: count. At REPEAT_PERIOD_CYCLES-1, strobe for one cycle and clear the counter.
  - Any state, held = 0: go to IDLE, counter cleared, no strobe that cycle.
- Strobe spacing:
  - First strobe: the cycle after held rises.
  - Second strobe: REPEAT_DELAY_CYCLES after the first.
  - Later strobes: every REPEAT_PERIOD_CYCLES.
- Conflict rule: while o_left_held and o_right_held are both 1, both strobe outputs are forced 0.
  - The FSMs keep counting, so timing is not reset.
  - The strobes themselves are suppressed, never deferred.
- o_left_debounced and o_right_debounced are never high in the same cycle.
- Strobes are registered outputs. Held outputs are registered.
- Counters saturate-free by construction: they clear at the terminal count and never wrap.

Optional Feature:
- Macro SHIP_AUTOREPEAT_EN.
- Defined: DELAY/REPEAT behaviour as above.
- Undefined: the FSM goes IDLE -> WAIT_RELEASE after the single press strobe, and returns to IDLE only when held falls. Exactly one strobe per press; the repeat counter and its logic are not synthesised.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=5):
- Reset held low, i_left_raw=1 for 20 cycles, then reset released -> all outputs 0 during reset; o_left_held rises 6 cycles after release; a single o_left_debounced pulse the next cycle.
- i_left_raw toggles every 2 cycles for 30 cycles -> o_left_held stays 0, no strobes.
- i_right_raw=1 for 40 cycles with auto-repeat enabled -> o_right_held rises at cycle 6; strobes at cycles 7, 17, 22, 27, 32, ...; releasing the button stops strobes, and o_right_held falls 6 cycles after the raw release.
- Same stimulus with SHIP_AUTOREPEAT_EN undefined -> exactly one strobe, at cycle 7.
- Left held stable, then right pressed -> right strobes suppressed and left strobes suppressed while both held; left repeats resume on schedule after right is released; never both strobes in one cycle.
- Reset asserted mid-REPEAT -> outputs 0 immediately (asynchronous); after release with the button still held, first strobe again at release+7.
